// File: rtl/stat_counter.sv
// rtl/stat_counter.sv - instruction-mix statistics counters with halt freeze and registered readout
// Define STAT_COUNTER_SAT_EN to make every counter saturate at all-ones and report a sticky sat flag.
module stat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             i,
  input  logic             r,
  input  logic             j,
  input  logic             halt,
  input  logic             clr,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] rdata,
  output logic             halted
);

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef STAT_COUNTER_SAT_EN
  localparam logic [WIDTH-1:0] ALL = {WIDTH{1'b1}};
`endif

  state_t state, state_nx;
  logic   count_en;
  logic   sat_flag;

  logic [WIDTH-1:0] cnt_total, cnt_r, cnt_i, cnt_j, cnt_other, cnt_cycle;
  logic [WIDTH-1:0] total_nx, r_nx, i_nx, j_nx, other_nx, cycle_nx;
  logic [WIDTH-1:0] rdata_nx;
  logic             retire, unflagged;

  function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] c, input logic en);
`ifdef STAT_COUNTER_SAT_EN
    return (en && (c != ALL)) ? c + ONE : c;
`else
    return en ? c + ONE : c;
`endif
  endfunction

  always_comb begin
    state_nx = state;
    count_en = 1'b0;
    if (clr) begin
      state_nx = ST_RUN;
    end else if (state == ST_RUN) begin
      count_en = 1'b1;
      if (halt) state_nx = ST_HALTED;
    end
  end

  assign halted    = (state == ST_HALTED);
  assign retire    = count_en & valid;
  assign unflagged = ~(i | r | j);

  assign total_nx = bump(cnt_total, retire);
  assign r_nx     = bump(cnt_r, retire & r);
  assign i_nx     = bump(cnt_i, retire & i);
  assign j_nx     = bump(cnt_j, retire & j);
  assign other_nx = bump(cnt_other, retire & unflagged);
  assign cycle_nx = bump(cnt_cycle, count_en);

`ifdef STAT_COUNTER_SAT_EN
  // Counters only grow between clears, so checking the post-update values catches every arrival.
  logic sat_nx;
  assign sat_nx = sat_flag | (total_nx == ALL) | (r_nx == ALL) | (i_nx == ALL) |
                  (j_nx == ALL) | (other_nx == ALL) | (cycle_nx == ALL);

  always_ff @(posedge clk) begin
    if (rst || clr) sat_flag <= 1'b0;
    else            sat_flag <= sat_nx;
  end
`else
  assign sat_flag = 1'b0;
`endif

  always_comb begin
    rdata_nx = '0;
    case (sel)
      3'd0: rdata_nx = cnt_total;
      3'd1: rdata_nx = cnt_r;
      3'd2: rdata_nx = cnt_i;
      3'd3: rdata_nx = cnt_j;
      3'd4: rdata_nx = cnt_other;
      3'd5: rdata_nx = cnt_cycle;
      3'd6: rdata_nx = {{(WIDTH-2){1'b0}}, sat_flag, halted};
      default: rdata_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      rdata     <= '0;
      cnt_total <= '0;
      cnt_r     <= '0;
      cnt_i     <= '0;
      cnt_j     <= '0;
      cnt_other <= '0;
      cnt_cycle <= '0;
    end else begin
      state <= state_nx;
      rdata <= rdata_nx;
      if (clr) begin
        cnt_total <= '0;
        cnt_r     <= '0;
        cnt_i     <= '0;
        cnt_j     <= '0;
        cnt_other <= '0;
        cnt_cycle <= '0;
      end else begin
        cnt_total <= total_nx;
        cnt_r     <= r_nx;
        cnt_i     <= i_nx;
        cnt_j     <= j_nx;
        cnt_other <= other_nx;
        cnt_cycle <= cycle_nx;
      end
    end
  end

endmodule

// File: tb/tb_stat_counter.sv
// tb/tb_stat_counter.sv - scoreboard bench for stat_counter at WIDTH=32 and WIDTH=4
module tb_stat_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, valid = 1'b0, i = 1'b0, r = 1'b0, j = 1'b0, halt = 1'b0, clr = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [31:0] rd32;
  logic [3:0]  rd4;
  logic        h32, h4;

  stat_counter #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .valid(valid), .i(i), .r(r), .j(j), .halt(halt), .clr(clr),
    .sel(sel), .rdata(rd32), .halted(h32)
  );

  stat_counter #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .valid(valid), .i(i), .r(r), .j(j), .halt(halt), .clr(clr),
    .sel(sel), .rdata(rd4), .halted(h4)
  );

  typedef struct packed {
    logic [31:0] e32;
    logic [3:0]  e4;
    logic        h;
  } exp_t;

  exp_t   q[$];
  int     compared = 0, mismatched = 0;
  // Unbounded event counts: 0 total, 1 r, 2 i, 3 j, 4 other, 5 cycle (matches sel encoding).
  longint cnt[6];
  bit     hm = 1'b0;

  function automatic longint fold(input longint c, input int w);
    longint mx = (longint'(1) << w) - 1;
`ifdef STAT_COUNTER_SAT_EN
    return (c > mx) ? mx : c;
`else
    return c & mx;
`endif
  endfunction

  function automatic longint view(input int s, input int w);
    longint mx = (longint'(1) << w) - 1;
    bit sat = 1'b0;
`ifdef STAT_COUNTER_SAT_EN
    for (int k = 0; k < 6; k++) if (cnt[k] >= mx) sat = 1'b1;
`endif
    if (s <= 5) return fold(cnt[s], w);
    if (s == 6) return (sat ? 2 : 0) + (hm ? 1 : 0);
    return 0;
  endfunction

  task automatic cmp(input string nm, input longint got, input longint exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, ii, rr, jj, hh, cc, rs, input int s);
    exp_t e;
    @(negedge clk);
    valid = v; i = ii; r = rr; j = jj; halt = hh; clr = cc; rst = rs; sel = 3'(s);
    e.e32 = rs ? 32'd0 : 32'(view(s, 32));
    e.e4  = rs ? 4'd0 : 4'(view(s, 4));
    if (rs || cc) begin
      for (int k = 0; k < 6; k++) cnt[k] = 0;
      hm = 1'b0;
    end else if (!hm) begin
      cnt[5]++;
      if (v) begin
        cnt[0]++;
        cnt[1] += longint'(rr);
        cnt[2] += longint'(ii);
        cnt[3] += longint'(jj);
        if (!(ii || rr || jj)) cnt[4]++;
      end
      if (hh) hm = 1'b1;
    end
    e.h = hm;
    q.push_back(e);
  endtask

  task automatic idle(input int s);
    drive(0, 0, 0, 0, 0, 0, 0, s);
  endtask

  task automatic chk(input string nm, input longint e32, input longint e4);
    @(posedge clk);
    #2;
    cmp({nm, "_w32"}, rd32, e32);
    cmp({nm, "_w4"}, rd4, e4);
  endtask

  task automatic rd(input string nm, input int s, input longint e32, input longint e4);
    idle(s);
    chk(nm, e32, e4);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("sb_rdata_w32", rd32, e.e32);
        cmp("sb_rdata_w4", rd4, e.e4);
        cmp("sb_halted_w32", h32, e.h);
        cmp("sb_halted_w4", h4, e.h);
      end
    end
  end

  initial begin : stim
    for (int k = 0; k < 6; k++) cnt[k] = 0;

    drive(0, 0, 0, 0, 0, 0, 1, 5);
    repeat (10) idle(5);
    rd("idle_cycle", 5, 10, 10);
    rd("idle_total", 0, 0, 0);
    rd("idle_other", 4, 0, 0);
    rd("idle_status", 6, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) drive(1, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) drive(1, 0, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    rd("mix_total", 0, 10, 10);
    rd("mix_r", 1, 4, 4);
    rd("mix_i", 2, 3, 3);
    rd("mix_j", 3, 2, 2);
    rd("mix_other", 4, 1, 1);

    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (5) drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 1, 0, 0, 1);
    rd("halt_status", 6, 1, 1);
    rd("halt_r", 1, 6, 6);
    repeat (20) drive(1, 1, 0, 0, 1, 0, 0, 0);
    rd("halt_total", 0, 6, 6);
    rd("halt_cycle", 5, 6, 6);

    drive(1, 1, 0, 0, 1, 1, 0, 2);
    rd("clr_i", 2, 0, 0);
    rd("clr_status", 6, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 2);
    rd("clr_i_after", 2, 1, 1);

    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    rd("lat_total", 0, 3, 3);
    idle(1);
    #1;
    cmp("lat_hold_w32", rd32, 3);
    chk("lat_r", 2, 2);

    drive(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (17) drive(1, 0, 1, 0, 0, 0, 0, 1);
`ifdef STAT_COUNTER_SAT_EN
    rd("wrap_r", 1, 17, 15);
    rd("wrap_status", 6, 0, 2);
`else
    rd("wrap_r", 1, 17, 1);
    rd("wrap_status", 6, 0, 0);
`endif

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 4) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom % 20) == 0, ($urandom % 30) == 0, ($urandom % 100) == 0,
            int'($urandom % 8));
    end
    idle(0);

    repeat (2) @(posedge clk);
    #3;
    cmp("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
